// File: rtl/io_input_port.sv
// Input side of the memory-mapped I/O region: synchronises, debounces and
// latches switch and push-button inputs, and answers CPU loads one cycle later.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   in_port0/1 [SW_W]       raw switch banks (asynchronous)
//   and_model/add_model     raw active-low buttons (1 = released)
//   rd_en, rd_addr[7:0]     CPU load strobe and byte address (bits [1:0] ignored)
//   io_read_data [DATA_W]   load data, held until the next read
//   rd_valid                one-cycle pulse one cycle after rd_en
//   btn_event               OR of the sticky press flags

module io_deb_chan #(
  parameter int W                = 1,
  parameter int DEB_CYCLES       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] deb_o,
  output logic         upd_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [W-1:0]  s1_q, s2_q, pend_q, deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mism, chg, upd;

  // chg: the pending (mismatching) value moved to another value,
  // so the new value starts its stability count from scratch.
  always_comb begin
    mism  = (s2_q != deb_q);
    chg   = (s2_q != pend_q) && (pend_q != deb_q);
    cnt_d = '0;
    deb_d = deb_q;
    upd   = 1'b0;
    if (mism) begin
      if (chg) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        deb_d = s2_q;
        upd   = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      pend_q <= RST_VAL;
      deb_q  <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      pend_q <= s2_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb_o = deb_q;
  assign upd_o = upd;

endmodule

module io_input_port #(
  parameter int SW_W       = 5,
  parameter int DEB_CYCLES = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SW_W-1:0]   in_port0,
  input  logic [SW_W-1:0]   in_port1,
  input  logic              and_model,
  input  logic              add_model,
  input  logic              rd_en,
  input  logic [7:0]        rd_addr,
  output logic [DATA_W-1:0] io_read_data,
  output logic              rd_valid,
  output logic              btn_event
);

  logic [SW_W-1:0]   p0_deb, p1_deb;
  logic              and_deb, add_deb;
  logic              p0_upd, p1_upd, and_upd, add_upd;
  logic [1:0]        flag_q, flag_d, press;
  logic              clr;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q;

  io_deb_chan #(.W(SW_W), .DEB_CYCLES(DEB_CYCLES), .RST_VAL('0)) u_p0 (
    .clock(clock), .reset(reset), .raw_i(in_port0),
    .deb_o(p0_deb), .upd_o(p0_upd)
  );

  io_deb_chan #(.W(SW_W), .DEB_CYCLES(DEB_CYCLES), .RST_VAL('0)) u_p1 (
    .clock(clock), .reset(reset), .raw_i(in_port1),
    .deb_o(p1_deb), .upd_o(p1_upd)
  );

  io_deb_chan #(.W(1), .DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_and (
    .clock(clock), .reset(reset), .raw_i(and_model),
    .deb_o(and_deb), .upd_o(and_upd)
  );

  io_deb_chan #(.W(1), .DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_add (
    .clock(clock), .reset(reset), .raw_i(add_model),
    .deb_o(add_deb), .upd_o(add_upd)
  );

  // A 1-bit update while the debounced level is 1 is a 1->0 press.
  assign press = {add_upd & add_deb, and_upd & and_deb};

  always_comb begin
    clr    = rd_en && (rd_addr[7:2] == 6'h23);
    flag_d = (clr ? 2'b00 : flag_q) | press;
    case (rd_addr[7:2])
      6'h20:   rdata_d = {{(DATA_W-SW_W){1'b0}}, p0_deb};
      6'h21:   rdata_d = {{(DATA_W-SW_W){1'b0}}, p1_deb};
      6'h22:   rdata_d = {{(DATA_W-2){1'b0}}, ~add_deb, ~and_deb};
      6'h23:   rdata_d = {{(DATA_W-2){1'b0}}, flag_q};
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_q   <= 2'b00;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      flag_q   <= flag_d;
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= rdata_d;
    end
  end

  assign io_read_data = rdata_q;
  assign rd_valid     = rvalid_q;
  assign btn_event    = |flag_q;

endmodule
